stream_mux2to1_arb: RTL
=======================

Name: stream_mux2to1_arb

Overview:
Merges two independent valid/ready packet streams (channel 0, channel 1) onto one output stream. It is the merge counterpart of the team's 1-to-2 demux: the demux steers one source to two sinks, and this block arbitrates two sources onto one sink. Arbitration happens only at packet boundaries, so packets are never interleaved. Output is registered, with one beat of storage, and each output beat is tagged with its source channel.

Parameters:
WIDTH, 8, data width of every channel
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 wins ties)
COUNT_W, 16, width of the per-channel completed-packet counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
In0_valid  input  1  channel 0 beat valid
In0_data  input  WIDTH  channel 0 data
In0_last  input  1  channel 0 final beat of packet
In0_ready  output  1  channel 0 beat accepted this cycle when high with In0_valid
In1_valid  input  1  channel 1 beat valid
In1_data  input  WIDTH  channel 1 data
In1_last  input  1  channel 1 final beat of packet
In1_ready  output  1  channel 1 beat accepted this cycle when high with In1_valid
Y_valid  output  1  output beat valid (registered)
Y_data  output  WIDTH  output data (registered)
Y_last  output  1  output final beat of packet (registered)
Y_src  output  1  source channel of the current output beat (registered)
Y_ready  input  1  downstream accepts the beat
Pkt_cnt0  output  COUNT_W  packets completed from channel 0
Pkt_cnt1  output  COUNT_W  packets completed from channel 1

Behaviour:
- Reset (async assert, sync release):
  - Y_valid, Y_data, Y_last, Y_src = 0.
  - Pkt_cnt0 and Pkt_cnt1 = 0.
  - State = IDLE.
  - last_grant = 1, so channel 0 wins the first tie.
- load = !Y_valid | Y_ready. The output register may be overwritten this cycle.
- Ready rules:
  - In*_ready is combinational and never asserted unless load = 1.
  - A non-granted channel's ready is 0.
  - Ready may depend on In*_valid; a valid input must not depend on ready.
- Grant in IDLE:
  - Only one channel valid: that channel.
  - Both valid with PRIORITY_MODE = 0: the channel != last_grant.
  - Both valid with PRIORITY_MODE = 1: channel 0.
  - Neither valid: no grant, and both readys = 0.
- State machine:
  - IDLE: on transfer from channel g (valid & ready):
    - last = 0: go to LOCK_g.
    - last = 1: stay in IDLE, last_grant <= g, increment Pkt_cnt_g.
  - LOCK0 / LOCK1:
    - Only the locked channel's ready = load; the other channel's ready = 0 regardless of its valid.
    - On a transfer with last = 1: go to IDLE, last_grant <= g, increment Pkt_cnt_g.
    - The lock is held indefinitely while the locked channel is idle mid-packet. There is no timeout.
- Transfer: Y_data/Y_last <= granted input, Y_src <= g, Y_valid <= 1. Latency is 1 cycle from input accept to Y_valid.
- Load with no transfer: Y_valid <= 0. Data fields hold their value (don't-care).
- Throughput: one beat per cycle sustained when Y_ready is held high. There are no bubbles at packet boundaries: a new grant is made in the same cycle the IDLE state is entered/held.
- Y_ready low while Y_valid = 1: Y_* stay stable, both In*_ready = 0.
- Counters: increment by 1 on a last-beat accept (not on output), and wrap from 2^COUNT_W-1 to 0.
- Simultaneous events:
  - A last-beat accept on one channel with the other valid: the other channel is granted next cycle (round-robin).
  - A single-beat packet counts as a complete packet.
- Reset mid-packet: the lock is dropped, any buffered beat is discarded (Y_valid = 0), and counters clear. The upstream partial packet is not tracked.

Test Plan:
- Reset then idle: rst pulse -> all Y_* = 0, both readys 0, Pkt_cnt0 = Pkt_cnt1 = 0.
- Single channel: In0 sends 3-beat packet 0x11,0x22,0x33 with last on 3rd, Y_ready = 1 -> Y_data 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after accept, Y_src = 0, Y_last on 0x33, Pkt_cnt0 = 1.
- Round-robin tie: both channels continuously offer 2-beat packets, PRIORITY_MODE = 0 -> output packet order ch0,ch1,ch0,ch1 with no interleaving, and no idle cycles between packets.
- Fixed priority: same stimulus with PRIORITY_MODE = 1 -> only ch0 packets appear, and In1_ready stays 0.
- Backpressure mid-packet: Y_ready low for 4 cycles during a ch1 packet while ch0 is valid -> Y_* frozen, In0_ready = 0 and In1_ready = 0. On release the ch1 packet completes before any ch0 beat.
- Counter wrap and reset: COUNT_W = 2, five single-beat ch0 packets -> Pkt_cnt0 = 1. Then assert rst mid-packet on ch1 -> Y_valid = 0 immediately, state IDLE, and ch0 wins the next tie.

Source files
------------

// File: rtl/stream_mux2to1_arb.sv
// Two-to-one valid/ready packet merge with packet-boundary arbitration.
// Registered single-beat output tagged with the source channel.
module stream_mux2to1_arb #(
    parameter int WIDTH         = 8,
    parameter int PRIORITY_MODE = 0,
    parameter int COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               In0_valid,
    input  logic [WIDTH-1:0]   In0_data,
    input  logic               In0_last,
    output logic               In0_ready,
    input  logic               In1_valid,
    input  logic [WIDTH-1:0]   In1_data,
    input  logic               In1_last,
    output logic               In1_ready,
    output logic               Y_valid,
    output logic [WIDTH-1:0]   Y_data,
    output logic               Y_last,
    output logic               Y_src,
    input  logic               Y_ready,
    output logic [COUNT_W-1:0] Pkt_cnt0,
    output logic [COUNT_W-1:0] Pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             last_grant, last_grant_nxt;
    logic             load;
    logic             gnt_vld;
    logic             gnt;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             xfer;

    assign load = !Y_valid || Y_ready;

    // Grant is re-decided every cycle spent in IDLE, so a new packet
    // can start in the same cycle the previous one finishes.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = 1'b0;
        case (state)
            IDLE: begin
                if (In0_valid && In1_valid) begin
                    gnt_vld = 1'b1;
                    gnt     = (PRIORITY_MODE != 0) ? 1'b0 : ~last_grant;
                end else if (In0_valid) begin
                    gnt_vld = 1'b1;
                    gnt     = 1'b0;
                end else if (In1_valid) begin
                    gnt_vld = 1'b1;
                    gnt     = 1'b1;
                end
            end
            LOCK0: begin
                gnt_vld = 1'b1;
                gnt     = 1'b0;
            end
            LOCK1: begin
                gnt_vld = 1'b1;
                gnt     = 1'b1;
            end
            default: begin
                gnt_vld = 1'b0;
                gnt     = 1'b0;
            end
        endcase
    end

    assign sel_valid = gnt ? In1_valid : In0_valid;
    assign sel_last  = gnt ? In1_last  : In0_last;
    assign sel_data  = gnt ? In1_data  : In0_data;

    assign In0_ready = load && gnt_vld && !gnt;
    assign In1_ready = load && gnt_vld && gnt;
    assign xfer      = load && gnt_vld && sel_valid;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        if (xfer) begin
            if (sel_last) begin
                state_nxt      = IDLE;
                last_grant_nxt = gnt;
            end else begin
                state_nxt = gnt ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y_valid <= 1'b0;
            Y_data  <= '0;
            Y_last  <= 1'b0;
            Y_src   <= 1'b0;
        end else if (load) begin
            Y_valid <= xfer;
            if (xfer) begin
                Y_data <= sel_data;
                Y_last <= sel_last;
                Y_src  <= gnt;
            end
        end
    end

    // Packets are counted when their last beat is accepted upstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Pkt_cnt0 <= '0;
            Pkt_cnt1 <= '0;
        end else if (xfer && sel_last) begin
            if (gnt) Pkt_cnt1 <= Pkt_cnt1 + 1'b1;
            else     Pkt_cnt0 <= Pkt_cnt0 + 1'b1;
        end
    end

endmodule
